// File: rtl/alu_4bit_checker.sv
// Response-side checker for alu_4bit: recomputes every applied vector's result,
// compares it against the DUT output LAT cycles later and records pass/fail statistics.
module alu_4bit_checker #(
  parameter int LAT  = 0,
  parameter int NVEC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        vld_in,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic        cin,
  input  logic [1:0]  s_op,
  input  logic [3:0]  z,
  input  logic        cout,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  pass_cnt,
  output logic [7:0]  fail_cnt,
  output logic [10:0] fail_vec,
  output logic [4:0]  fail_got,
  output logic [4:0]  fail_exp
);

  localparam logic [7:0] NVEC_C = 8'(NVEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [4:0] ref_model(input logic [1:0] op, input logic ci,
                                           input logic [3:0] x, input logic [3:0] y);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
      2'b01:   r = {1'b0, x} + {1'b0, ~y} + {4'b0000, ci};
      2'b10:   r = {1'b0, x & y};
      default: r = {1'b0, x ^ y};
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  issue_q, issue_d;
  logic [7:0]  pass_q, pass_d;
  logic [7:0]  fail_q, fail_d;
  logic        err_q, err_d;
  logic [10:0] fvec_q, fvec_d;
  logic [4:0]  fgot_q, fgot_d;
  logic [4:0]  fexp_q, fexp_d;

  logic        vld_p0_q, vld_p1_q, vld_p2_q;
  logic [10:0] vec_p0_q, vec_p1_q, vec_p2_q;
  logic [4:0]  exp_p0_q, exp_p1_q, exp_p2_q;

  logic        accept;
  logic        start_ok;
  logic [10:0] vec_in;
  logic [4:0]  exp_in;
  logic        cmp_vld;
  logic [10:0] cmp_vec;
  logic [4:0]  cmp_exp;
  logic [4:0]  got;
  logic        mism;
  logic        pipe_busy;

  // Once the NVECth vector is taken the FSM leaves RUN, so later vectors fall away here.
  assign accept   = (state_q == S_RUN) && vld_in;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign vec_in   = {s_op, cin, a, b};
  assign exp_in   = ref_model(s_op, cin, a, b);
  assign got      = {cout, z};

  // Stage p0..p2: expected-value delay line; the tail sits at stage LAT-1
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= accept;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    vec_p0_q <= vec_in;
    exp_p0_q <= exp_in;
    vec_p1_q <= vec_p0_q;
    exp_p1_q <= exp_p0_q;
    vec_p2_q <= vec_p1_q;
    exp_p2_q <= exp_p1_q;
  end

  always_comb begin
    cmp_vld = accept;
    cmp_vec = vec_in;
    cmp_exp = exp_in;
    case (LAT)
      0: begin
        cmp_vld = accept;
        cmp_vec = vec_in;
        cmp_exp = exp_in;
      end
      1: begin
        cmp_vld = vld_p0_q;
        cmp_vec = vec_p0_q;
        cmp_exp = exp_p0_q;
      end
      2: begin
        cmp_vld = vld_p1_q;
        cmp_vec = vec_p1_q;
        cmp_exp = exp_p1_q;
      end
      default: begin
        cmp_vld = vld_p2_q;
        cmp_vec = vec_p2_q;
        cmp_exp = exp_p2_q;
      end
    endcase
  end

  always_comb begin
    pipe_busy = 1'b0;
    if (LAT >= 1) pipe_busy = pipe_busy | vld_p0_q;
    if (LAT >= 2) pipe_busy = pipe_busy | vld_p1_q;
    if (LAT >= 3) pipe_busy = pipe_busy | vld_p2_q;
  end

  assign mism = cmp_vld && (got != cmp_exp);

  // Compare stage: next-state, counters and first-failure capture
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fgot_d  = fgot_q;
    fexp_d  = fexp_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          issue_d = issue_q + 8'd1;
          if (issue_d == NVEC_C) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    if (cmp_vld) begin
      if (mism) begin
        fail_d = sat_inc(fail_q);
        err_d  = 1'b1;
        if (!err_q) begin
          fvec_d = cmp_vec;
          fgot_d = got;
          fexp_d = cmp_exp;
        end
      end else begin
        pass_d = sat_inc(pass_q);
      end
    end

    // The delay line is empty in IDLE/DONE, so clearing here never drops a compare.
    if (start_ok) begin
      issue_d = 8'd0;
      pass_d  = 8'd0;
      fail_d  = 8'd0;
      err_d   = 1'b0;
      fvec_d  = 11'd0;
      fgot_d  = 5'd0;
      fexp_d  = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      issue_q <= 8'd0;
      pass_q  <= 8'd0;
      fail_q  <= 8'd0;
      err_q   <= 1'b0;
      fvec_q  <= 11'd0;
      fgot_q  <= 5'd0;
      fexp_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fgot_q  <= fgot_d;
      fexp_q  <= fexp_d;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign fail_vec = fvec_q;
  assign fail_got = fgot_q;
  assign fail_exp = fexp_q;

endmodule

// File: tb/tb_alu_4bit_checker.sv
// Bench for alu_4bit_checker: four checker instances with different LAT/NVEC, fed
// by a behavioural ALU whose response can be corrupted and delayed per instance.
module tb_alu_4bit_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a, b;
  logic        cin;
  logic [1:0]  s_op;
  logic        corrupt;
  logic        start_v [4];
  logic        vld_v   [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        err_v   [4];
  logic [7:0]  pass_v  [4];
  logic [7:0]  fail_v  [4];
  logic [10:0] fvec_v  [4];
  logic [4:0]  fgot_v  [4];
  logic [4:0]  fexp_v  [4];
  logic [4:0]  resp_now, d1, d2, d3;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: plain integer arithmetic, result truncated to {cout, z}
  function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] x,
                                         input logic [3:0] y, input logic c);
    int r;
    case (op)
      2'd0:    r = int'(x) + int'(y) + int'(c);
      2'd1:    r = int'(x) + (15 - int'(y)) + int'(c);
      2'd2:    r = int'(x & y);
      default: r = int'(x ^ y);
    endcase
    return 5'(r);
  endfunction

  assign resp_now = alu_ref(s_op, a, b, cin) ^ {4'b0000, corrupt};

  always @(posedge clk) begin
    d1 <= resp_now;
    d2 <= d1;
    d3 <= d2;
  end

  alu_4bit_checker #(.LAT(0), .NVEC(4)) u_l0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .vld_in(vld_v[0]), .a(a), .b(b), .cin(cin),
    .s_op(s_op), .z(resp_now[3:0]), .cout(resp_now[4]), .busy(busy_v[0]), .done(done_v[0]),
    .err(err_v[0]), .pass_cnt(pass_v[0]), .fail_cnt(fail_v[0]), .fail_vec(fvec_v[0]),
    .fail_got(fgot_v[0]), .fail_exp(fexp_v[0]));

  alu_4bit_checker #(.LAT(2), .NVEC(1)) u_l2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .vld_in(vld_v[1]), .a(a), .b(b), .cin(cin),
    .s_op(s_op), .z(d2[3:0]), .cout(d2[4]), .busy(busy_v[1]), .done(done_v[1]),
    .err(err_v[1]), .pass_cnt(pass_v[1]), .fail_cnt(fail_v[1]), .fail_vec(fvec_v[1]),
    .fail_got(fgot_v[1]), .fail_exp(fexp_v[1]));

  alu_4bit_checker #(.LAT(3), .NVEC(4)) u_l3 (
    .clk(clk), .rst(rst), .start(start_v[2]), .vld_in(vld_v[2]), .a(a), .b(b), .cin(cin),
    .s_op(s_op), .z(d3[3:0]), .cout(d3[4]), .busy(busy_v[2]), .done(done_v[2]),
    .err(err_v[2]), .pass_cnt(pass_v[2]), .fail_cnt(fail_v[2]), .fail_vec(fvec_v[2]),
    .fail_got(fgot_v[2]), .fail_exp(fexp_v[2]));

  alu_4bit_checker #(.LAT(0), .NVEC(255)) u_sat (
    .clk(clk), .rst(rst), .start(start_v[3]), .vld_in(vld_v[3]), .a(a), .b(b), .cin(cin),
    .s_op(s_op), .z(resp_now[3:0]), .cout(resp_now[4]), .busy(busy_v[3]), .done(done_v[3]),
    .err(err_v[3]), .pass_cnt(pass_v[3]), .fail_cnt(fail_v[3]), .fail_vec(fvec_v[3]),
    .fail_got(fgot_v[3]), .fail_exp(fexp_v[3]));

  // All stimulus changes happen at a falling edge; outputs are sampled there too.
  task automatic start_run(input int idx);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic issue(input int idx, input logic [1:0] op, input logic [3:0] x,
                       input logic [3:0] y, input logic c, input logic bad);
    s_op = op; a = x; b = y; cin = c; corrupt = bad;
    vld_v[idx] = 1'b1;
    @(negedge clk);
    vld_v[idx] = 1'b0;
    corrupt = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (busy_v[i] !== 1'b0) begin n_errors++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy_v[i]); end
      n_checks++; if (done_v[i] !== 1'b0) begin n_errors++; $display("FAIL reset_done[%0d] got=%b exp=0", i, done_v[i]); end
      n_checks++; if (err_v[i] !== 1'b0) begin n_errors++; $display("FAIL reset_err[%0d] got=%b exp=0", i, err_v[i]); end
      n_checks++; if (pass_v[i] !== 8'd0 || fail_v[i] !== 8'd0) begin n_errors++; $display("FAIL reset_cnt[%0d] got=%0d/%0d exp=0/0", i, pass_v[i], fail_v[i]); end
      n_checks++; if ({fvec_v[i], fgot_v[i], fexp_v[i]} !== 21'd0) begin n_errors++; $display("FAIL reset_capture[%0d] got=%h exp=0", i, {fvec_v[i], fgot_v[i], fexp_v[i]}); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    start_run(0);
    n_checks++; if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin n_errors++; $display("FAIL basic_start busy/done got=%b%b exp=10", busy_v[0], done_v[0]); end
    issue(0, 2'b00, 4'd2, 4'd2, 1'b0, 1'b0);
    issue(0, 2'b01, 4'd2, 4'd3, 1'b1, 1'b0);
    issue(0, 2'b10, 4'd2, 4'd2, 1'b1, 1'b0);
    issue(0, 2'b11, 4'd2, 4'd6, 1'b1, 1'b0);
    n_checks++; if (pass_v[0] !== 8'd4) begin n_errors++; $display("FAIL basic_pass got=%0d exp=4", pass_v[0]); end
    n_checks++; if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin n_errors++; $display("FAIL basic_drain busy/done got=%b%b exp=10", busy_v[0], done_v[0]); end
    @(negedge clk);
    n_checks++; if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin n_errors++; $display("FAIL basic_done busy/done got=%b%b exp=01", busy_v[0], done_v[0]); end
    n_checks++; if (fail_v[0] !== 8'd0 || err_v[0] !== 1'b0) begin n_errors++; $display("FAIL basic_fail fail/err got=%0d/%b exp=0/0", fail_v[0], err_v[0]); end
  endtask

  task automatic test_first_fail;
    start_run(0);
    issue(0, 2'b00, 4'd2, 4'd2, 1'b0, 1'b1);
    issue(0, 2'b01, 4'd2, 4'd3, 1'b1, 1'b0);
    issue(0, 2'b10, 4'd2, 4'd2, 1'b1, 1'b0);
    issue(0, 2'b11, 4'd2, 4'd6, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (done_v[0] !== 1'b1) begin n_errors++; $display("FAIL ff_done got=%b exp=1", done_v[0]); end
    n_checks++; if (err_v[0] !== 1'b1) begin n_errors++; $display("FAIL ff_err got=%b exp=1", err_v[0]); end
    n_checks++; if (fail_v[0] !== 8'd1 || pass_v[0] !== 8'd3) begin n_errors++; $display("FAIL ff_cnt fail/pass got=%0d/%0d exp=1/3", fail_v[0], pass_v[0]); end
    n_checks++; if (fvec_v[0] !== 11'b00_0_0010_0010) begin n_errors++; $display("FAIL ff_vec got=%h exp=%h", fvec_v[0], 11'b00_0_0010_0010); end
    n_checks++; if (fgot_v[0] !== 5'h05) begin n_errors++; $display("FAIL ff_got got=%h exp=05", fgot_v[0]); end
    n_checks++; if (fexp_v[0] !== 5'h04) begin n_errors++; $display("FAIL ff_exp got=%h exp=04", fexp_v[0]); end
  endtask

  task automatic test_restart_clear;
    start_run(0);
    n_checks++; if (err_v[0] !== 1'b0 || pass_v[0] !== 8'd0 || fail_v[0] !== 8'd0) begin n_errors++; $display("FAIL clr_cnt err/pass/fail got=%b/%0d/%0d exp=0/0/0", err_v[0], pass_v[0], fail_v[0]); end
    n_checks++; if ({fvec_v[0], fgot_v[0], fexp_v[0]} !== 21'd0) begin n_errors++; $display("FAIL clr_capture got=%h exp=0", {fvec_v[0], fgot_v[0], fexp_v[0]}); end
    n_checks++; if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin n_errors++; $display("FAIL clr_busy busy/done got=%b%b exp=10", busy_v[0], done_v[0]); end
    for (int k = 0; k < 4; k++) issue(0, 2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    @(negedge clk);
    n_checks++; if (done_v[0] !== 1'b1 || pass_v[0] !== 8'd4) begin n_errors++; $display("FAIL clr_rerun done/pass got=%b/%0d exp=1/4", done_v[0], pass_v[0]); end
  endtask

  task automatic test_back_to_back;
    // start held high the whole run; the vector on the start cycle must be ignored
    s_op = 2'b00; a = 4'd1; b = 4'd1; cin = 1'b0; corrupt = 1'b1;
    start_v[0] = 1'b1; vld_v[0] = 1'b1;
    @(negedge clk);
    vld_v[0] = 1'b0; corrupt = 1'b0;
    issue(0, 2'b00, 4'd2, 4'd2, 1'b0, 1'b0);
    issue(0, 2'b01, 4'd2, 4'd3, 1'b1, 1'b0);
    issue(0, 2'b10, 4'd2, 4'd2, 1'b1, 1'b1);
    issue(0, 2'b11, 4'd2, 4'd6, 1'b1, 1'b0);
    start_v[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (done_v[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_done got=%b exp=1", done_v[0]); end
    n_checks++; if (pass_v[0] !== 8'd3 || fail_v[0] !== 8'd1) begin n_errors++; $display("FAIL b2b_cnt pass/fail got=%0d/%0d exp=3/1", pass_v[0], fail_v[0]); end
    n_checks++; if (fvec_v[0] !== {2'b10, 1'b1, 4'd2, 4'd2} || fgot_v[0] !== 5'h03 || fexp_v[0] !== 5'h02) begin
      n_errors++; $display("FAIL b2b_capture vec/got/exp got=%h/%h/%h exp=%h/03/02", fvec_v[0], fgot_v[0], fexp_v[0], {2'b10, 1'b1, 4'd2, 4'd2}); end
  endtask

  task automatic test_latency;
    start_run(1);
    issue(1, 2'b00, 4'hF, 4'h1, 1'b0, 1'b0);
    n_checks++; if (pass_v[1] !== 8'd0) begin n_errors++; $display("FAIL lat_edge0 pass got=%0d exp=0", pass_v[1]); end
    @(negedge clk);
    n_checks++; if (pass_v[1] !== 8'd0) begin n_errors++; $display("FAIL lat_edge1 pass got=%0d exp=0", pass_v[1]); end
    @(negedge clk);
    n_checks++; if (pass_v[1] !== 8'd1 || done_v[1] !== 1'b0) begin n_errors++; $display("FAIL lat_edge2 pass/done got=%0d/%b exp=1/0", pass_v[1], done_v[1]); end
    @(negedge clk);
    n_checks++; if (done_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin n_errors++; $display("FAIL lat_done busy/done got=%b%b exp=01", busy_v[1], done_v[1]); end
    n_checks++; if (fail_v[1] !== 8'd0 || err_v[1] !== 1'b0) begin n_errors++; $display("FAIL lat_fail fail/err got=%0d/%b exp=0/0", fail_v[1], err_v[1]); end
  endtask

  task automatic test_saturate;
    logic [1:0]  op;
    logic [3:0]  x, y;
    logic        c;
    logic [10:0] first_vec;
    logic [4:0]  first_exp;
    first_vec = '0; first_exp = '0;
    start_run(3);
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom); x = 4'($urandom); y = 4'($urandom); c = 1'($urandom);
      if (i == 0) begin first_vec = {op, c, x, y}; first_exp = alu_ref(op, x, y, c); end
      issue(3, op, x, y, c, 1'b1);
    end
    n_checks++; if (fail_v[3] !== 8'd255) begin n_errors++; $display("FAIL sat_fail got=%0d exp=255", fail_v[3]); end
    n_checks++; if (pass_v[3] !== 8'd0 || err_v[3] !== 1'b1 || done_v[3] !== 1'b1) begin n_errors++; $display("FAIL sat_state pass/err/done got=%0d/%b/%b exp=0/1/1", pass_v[3], err_v[3], done_v[3]); end
    n_checks++; if (fvec_v[3] !== first_vec || fexp_v[3] !== first_exp || fgot_v[3] !== (first_exp ^ 5'h01)) begin
      n_errors++; $display("FAIL sat_capture vec/got/exp got=%h/%h/%h exp=%h/%h/%h", fvec_v[3], fgot_v[3], fexp_v[3], first_vec, first_exp ^ 5'h01, first_exp); end
  endtask

  task automatic test_random(input int idx, input int runs);
    logic [1:0]  op;
    logic [3:0]  x, y;
    logic        c, bad;
    logic [4:0]  e;
    int          exp_pass, exp_fail;
    logic        exp_err;
    logic [10:0] fv;
    logic [4:0]  fg, fe;
    for (int r = 0; r < runs; r++) begin
      exp_pass = 0; exp_fail = 0; exp_err = 1'b0; fv = '0; fg = '0; fe = '0;
      start_run(idx);
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        op = 2'($urandom); x = 4'($urandom); y = 4'($urandom); c = 1'($urandom);
        bad = ($urandom_range(0, 3) == 0);
        e = alu_ref(op, x, y, c);
        if (bad) begin
          exp_fail++;
          if (!exp_err) begin fv = {op, c, x, y}; fg = e ^ 5'h01; fe = e; exp_err = 1'b1; end
        end else begin
          exp_pass++;
        end
        issue(idx, op, x, y, c, bad);
      end
      for (int i = 0; i < 20 && done_v[idx] !== 1'b1; i++) @(negedge clk);
      n_checks++; if (done_v[idx] !== 1'b1) begin n_errors++; $display("FAIL rnd_done[%0d] got=%b exp=1", idx, done_v[idx]); end
      n_checks++; if (pass_v[idx] !== 8'(exp_pass) || fail_v[idx] !== 8'(exp_fail)) begin
        n_errors++; $display("FAIL rnd_cnt[%0d] pass/fail got=%0d/%0d exp=%0d/%0d", idx, pass_v[idx], fail_v[idx], exp_pass, exp_fail); end
      n_checks++; if (err_v[idx] !== exp_err) begin n_errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", idx, err_v[idx], exp_err); end
      n_checks++; if (fvec_v[idx] !== fv || fgot_v[idx] !== fg || fexp_v[idx] !== fe) begin
        n_errors++; $display("FAIL rnd_capture[%0d] vec/got/exp got=%h/%h/%h exp=%h/%h/%h", idx, fvec_v[idx], fgot_v[idx], fexp_v[idx], fv, fg, fe); end
    end
  endtask

  task automatic test_reset_midrun;
    start_run(2);
    issue(2, 2'b00, 4'd3, 4'd4, 1'b0, 1'b0);
    issue(2, 2'b01, 4'd9, 4'd4, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0 || err_v[2] !== 1'b0) begin n_errors++; $display("FAIL rstrun_state busy/done/err got=%b%b%b exp=000", busy_v[2], done_v[2], err_v[2]); end
    n_checks++; if ({pass_v[2], fail_v[2], fvec_v[2], fgot_v[2], fexp_v[2]} !== 37'd0) begin
      n_errors++; $display("FAIL rstrun_regs got=%h exp=0", {pass_v[2], fail_v[2], fvec_v[2], fgot_v[2], fexp_v[2]}); end
    repeat (4) @(negedge clk);
    n_checks++; if (pass_v[2] !== 8'd0 || fail_v[2] !== 8'd0 || busy_v[2] !== 1'b0) begin
      n_errors++; $display("FAIL rstrun_flushed pass/fail/busy got=%0d/%0d/%b exp=0/0/0", pass_v[2], fail_v[2], busy_v[2]); end
    start_run(2);
    issue(2, 2'b11, 4'd5, 4'd10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (pass_v[2] !== 8'd1 || fail_v[2] !== 8'd0) begin n_errors++; $display("FAIL rstrun_after pass/fail got=%0d/%0d exp=1/0", pass_v[2], fail_v[2]); end
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; s_op = '0; corrupt = 1'b0;
    for (int i = 0; i < 4; i++) begin start_v[i] = 1'b0; vld_v[i] = 1'b0; end
    test_reset();
    test_basic();
    test_first_fail();
    test_restart_clear();
    test_back_to_back();
    test_latency();
    test_saturate();
    test_random(0, 6);
    test_random(2, 6);
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/alu_4bit_checker.md
# alu_4bit_checker

Synthesizable response-side checker for `alu_4bit`. It sees each operand vector applied to the ALU and each `z`/`cout` the ALU returns. It computes the expected result with an internal reference model and compares it against the DUT output after a fixed pipeline latency. It keeps pass/fail counts and captures the first failing vector, so on-chip and FPGA runs self-check without a `$display` log.

## Interface

Parameters:
- `LAT`, default 0: DUT latency in clock cycles, from vector applied to `z`/`cout` valid. Legal range 0..3.
- `NVEC`, default 16: number of vectors in one check run. Legal range 1..255.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begins a run. Honoured only in IDLE or DONE.
- `vld_in`, input, 1: `a`/`b`/`cin`/`s_op` carry a vector applied to the DUT this cycle.
- `a`, input, 4: ALU operand A, as driven to the DUT.
- `b`, input, 4: ALU operand B, as driven to the DUT.
- `cin`, input, 1: ALU carry-in, as driven to the DUT.
- `s_op`, input, 2: ALU op select, as driven to the DUT.
- `z`, input, 4: DUT result.
- `cout`, input, 1: DUT carry-out.
- `busy`, output, 1: high in RUN and DRAIN.
- `done`, output, 1: high in DONE.
- `err`, output, 1: sticky. Set on the first mismatch of a run.
- `pass_cnt`, output, 8: number of matching compares. Saturates at 255.
- `fail_cnt`, output, 8: number of mismatching compares. Saturates at 255.
- `fail_vec`, output, 11: first failing vector, packed as {`s_op`, `cin`, `a`, `b`}.
- `fail_got`, output, 5: DUT {`cout`, `z`} at the first failure.
- `fail_exp`, output, 5: expected {`cout`, `z`} at the first failure.

## Operation

Reference model (5-bit result {`cout`, `z`}):
- `s_op` 00: a + b + cin.
- `s_op` 01: a + ~b + cin. This is subtract when cin=1.
- `s_op` 10: a & b, with cout = 0.
- `s_op` 11: a ^ b, with cout = 0.
- Arithmetic is unsigned and zero-extended to 5 bits. The carry is bit 4.

State machine:
- IDLE: on `start`, go to RUN.
- RUN: each cycle with `vld_in`=1, accept the vector and increment the issue count. When issue count reaches `NVEC`, go to DRAIN. Vectors arriving after that are ignored.
- DRAIN: when no compares are outstanding in the delay line, go to DONE.
- DONE: hold all results. `start` returns to RUN.

Run setup:
- Leaving IDLE or DONE on `start` clears `err`, both counters, the issue count and all `fail_*` registers in the same edge.
- `vld_in` in IDLE, DONE, or on the `start` cycle itself is ignored.

Expected-value pipeline:
- A delay line `LAT` deep carries {valid, vector, expected}.
- The compare is performed when a valid entry reaches the tail, against the DUT's `z`/`cout` in that same cycle.
- `LAT`=0 means the compare uses the current-cycle `vld_in` and `z`/`cout` directly.

Compare and capture:
- A match increments `pass_cnt`. A mismatch increments `fail_cnt` and sets `err`.
- `fail_*` registers load only when `err` was 0 before this compare, i.e. on the first failure only.

## Timing

Reset:
- `rst` sampled high at an edge forces IDLE.
- It also clears `busy`, `done`, `err`, `pass_cnt`, `fail_cnt`, all `fail_*` registers and the delay-line valids.
- `rst` takes priority over `start` and `vld_in`.
- `rst` mid-run discards in-flight compares. No counter changes on that edge.

Compare latency:
- A vector accepted at edge N is compared using `z`/`cout` sampled at edge N+`LAT`.
- Counters and `err` show the result after edge N+`LAT`.

State output timing:
- `done` rises one cycle after the last outstanding compare retires.
- For `LAT`=0, `done` rises at the edge after the `NVEC`th accept: RUN, then DRAIN for one cycle, then DONE.
- `busy` and `done` are never high together.

Boundary conditions:
- Back-to-back `vld_in` at full rate is supported. No stalls, no backpressure.
- Gaps in `vld_in` are allowed, and only valid entries compare.
- Counters hold at 255 and do not wrap.
- `start` while in RUN or DRAIN is ignored.

## Test plan

- `LAT`=0, `NVEC`=4. Vectors (s_op, a, b, cin) = (00, 2, 2, 0), (01, 2, 3, 1), (10, 2, 2, 1), (11, 2, 6, 1), with a correct DUT model returning z = 4, 15, 2, 4 and cout = 0, 0, 0, 0 -> `pass_cnt`=4, `fail_cnt`=0, `err`=0, `done`=1 one cycle after the 4th vector.
- Same sequence, but the DUT returns z=5 on vector 1 (the first vector, (00, 2, 2, 0)) -> `err`=1, `fail_cnt`=1, `pass_cnt`=3, `fail_vec`={00, 0, 0010, 0010}, `fail_got`=5'h05, `fail_exp`=5'h04.
- `LAT`=2, DUT model delayed 2 cycles, 0xF+0x1+0 (cout=1, z=0) as the only vector with `NVEC`=1 -> a pass is counted exactly 2 edges after acceptance; `done` follows one cycle later.
- `NVEC`=255, every compare forced to mismatch, 300 `vld_in` pulses -> `fail_cnt` saturates at 255; the 45 extra vectors are ignored; `fail_*` registers hold the first failure.
- Assert `rst` in RUN with `LAT`=3 and 2 compares in flight -> all outputs 0, state IDLE, no count change; a later `start` plus 1 vector gives `pass_cnt`=1.
- In DONE with `err`=1, assert `start` -> counters, `err` and `fail_*` clear on the same edge; `busy`=1.
